// File: rtl/maxpool_2x2.sv
`default_nettype none
// ============================================================================
// Module      : maxpool_2x2
// Description : Streaming 2x2 max pooling, stride 2, on a D x D raster of
//               IEEE-754 single-precision pixels. Horizontal pair maxima of
//               each even row are kept in a one-row buffer. On the following
//               odd row they are combined with that row's pair maxima, so no
//               frame storage is needed.
//               When D is odd, the last column and the last row are consumed
//               but produce no output.
// Ports       : clk       - clock, rising edge
//               reset     - asynchronous, active-high reset
//               valid_in  - pxl_in carries a pixel this cycle
//               pxl_in    - input pixel, raster order
//               pxl_out   - pooled pixel, held between strobes
//               valid_out - one-cycle strobe per pooled pixel
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool_2x2 #(
  parameter int D          = 299,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out
);

  // Pooled frame edge and the counter / buffer-index widths.
  // c_CW holds D itself, so the pooled-area limit 2*P always fits.
  localparam int c_P  = D / 2;
  localparam int c_CW = $clog2(D + 1);
  localparam int c_LW = (c_P > 1) ? $clog2(c_P) : 1;

  localparam logic [c_CW-1:0] c_LAST = c_CW'(D - 1);
  localparam logic [c_CW-1:0] c_LIM  = c_CW'(2 * c_P);

  // Ordering on raw float bits. Positive beats negative, so +0.0 beats -0.0.
  // For same-sign operands, magnitude order follows the unsigned bit order;
  // for negative operands that order is reversed.
  // NaN and Inf simply take part in the same bit ordering.
  function automatic logic [DATA_WIDTH-1:0] fmax(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic sa;
    logic sb;
    sa = a[DATA_WIDTH-1];
    sb = b[DATA_WIDTH-1];
    if (sa != sb)
      fmax = sa ? b : a;
    else if (!sa)
      fmax = (a > b) ? a : b;
    else
      fmax = (a < b) ? a : b;
  endfunction

  logic [c_CW-1:0]       r_col;
  logic [c_CW-1:0]       r_row;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_pxl;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_linebuf [c_P];

  logic                  w_col_last;
  logic                  w_row_last;
  logic                  w_in_area;
  logic [c_LW-1:0]       w_lb_idx;
  logic [DATA_WIDTH-1:0] w_lb_rd;
  logic [DATA_WIDTH-1:0] w_pair;
  logic [DATA_WIDTH-1:0] w_quad;
  logic                  w_lb_we;

  assign w_col_last = (r_col == c_LAST);
  assign w_row_last = (r_row == c_LAST);

  // The trailing odd column/row of an odd-sized frame falls outside this area.
  assign w_in_area  = (r_col < c_LIM) && (r_row < c_LIM);

  assign w_lb_idx   = c_LW'(r_col >> 1);
  assign w_lb_rd    = r_linebuf[w_lb_idx];
  assign w_pair     = fmax(r_hold, pxl_in);
  assign w_quad     = fmax(w_lb_rd, w_pair);

  // Each pair slot is written on the even row before it is read on the odd
  // row. The buffer therefore needs no reset.
  assign w_lb_we    = valid_in && w_in_area && r_col[0] && !r_row[0];

  always_ff @(posedge clk) begin
    if (w_lb_we)
      r_linebuf[w_lb_idx] <= w_pair;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col   <= '0;
      r_row   <= '0;
      r_hold  <= '0;
      r_pxl   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (valid_in) begin
        // Raster position of the next pixel
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end

        // Window bookkeeping for the pixel accepted this cycle
        if (w_in_area) begin
          if (!r_col[0]) begin
            r_hold <= pxl_in;
          end else if (r_row[0]) begin
            r_pxl   <= w_quad;
            r_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign pxl_out   = r_pxl;
  assign valid_out = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_2x2.sv
`default_nettype none
// ============================================================================
// Module      : tb_maxpool_2x2
// Description : Self-checking bench for maxpool_2x2. Four instances are built
//               with different frame edges (2, 4, 5 and 11) and are exercised
//               one at a time. A negedge monitor collects every output
//               strobe. Expected values come from constants or from a
//               frame-level pooling model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maxpool_2x2;

  typedef logic [31:0] pq_t [$];
  typedef struct packed {
    logic [1:0]  dut;
    logic [31:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        vin  [4];
  logic [31:0] pin  [4];
  logic [31:0] pout [4];
  logic        vout [4];

  int  n_checks = 0;
  int  n_fail   = 0;
  ev_t mon_q [$];

  always #5 clk = ~clk;

  maxpool_2x2 #(.D(2), .DATA_WIDTH(32)) u_d2 (
    .clk(clk), .reset(rst), .valid_in(vin[0]), .pxl_in(pin[0]),
    .pxl_out(pout[0]), .valid_out(vout[0]));
  maxpool_2x2 #(.D(4), .DATA_WIDTH(32)) u_d4 (
    .clk(clk), .reset(rst), .valid_in(vin[1]), .pxl_in(pin[1]),
    .pxl_out(pout[1]), .valid_out(vout[1]));
  maxpool_2x2 #(.D(5), .DATA_WIDTH(32)) u_d5 (
    .clk(clk), .reset(rst), .valid_in(vin[2]), .pxl_in(pin[2]),
    .pxl_out(pout[2]), .valid_out(vout[2]));
  maxpool_2x2 #(.D(11), .DATA_WIDTH(32)) u_d11 (
    .clk(clk), .reset(rst), .valid_in(vin[3]), .pxl_in(pin[3]),
    .pxl_out(pout[3]), .valid_out(vout[3]));

  // Output monitor: every strobe of every instance, tagged by instance
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++)
      if (vout[k] === 1'b1)
        mon_q.push_back('{dut: 2'(k), val: pout[k]});
  end

  // ---------------------------------------------------------------- model
  // Positive integer to single-precision bits
  function automatic logic [31:0] itof(input int n);
    int e;
    logic [31:0] m;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    m = (32'(n) << (23 - e)) & 32'h007F_FFFF;
    return {1'b0, 8'(e + 127), m[22:0]};
  endfunction

  // Map float bits to a key whose unsigned order is the float order
  // (with -0.0 below +0.0)
  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic [31:0] fmax_ref(input logic [31:0] a, input logic [31:0] b);
    return (fkey(a) >= fkey(b)) ? a : b;
  endfunction

  // Pool every complete D x D frame in the pixel list
  function automatic pq_t pool_ref(input int dsz, input pq_t pix);
    pq_t res;
    int  p, nf, base;
    logic [31:0] m;
    p  = dsz / 2;
    nf = pix.size() / (dsz * dsz);
    for (int f = 0; f < nf; f++) begin
      base = f * dsz * dsz;
      for (int r = 0; r < p; r++)
        for (int c = 0; c < p; c++) begin
          m = pix[base + (2*r) * dsz + 2*c];
          m = fmax_ref(m, pix[base + (2*r) * dsz + 2*c + 1]);
          m = fmax_ref(m, pix[base + (2*r + 1) * dsz + 2*c]);
          m = fmax_ref(m, pix[base + (2*r + 1) * dsz + 2*c + 1]);
          res.push_back(m);
        end
    end
    return res;
  endfunction

  function automatic pq_t ramp(input int n);
    pq_t q;
    for (int i = 1; i <= n; i++) q.push_back(itof(i));
    return q;
  endfunction

  // Feed a pixel list to instance k, inserting idle cycles with the given
  // percentage probability; idle cycles carry garbage on pxl_in.
  task automatic drive(input int k, input pq_t pix, input int idle_pct);
    for (int i = 0; i < pix.size(); i++) begin
      while (int'($urandom_range(99)) < idle_pct) begin
        @(negedge clk);
        vin[k] = 1'b0;
        pin[k] = $urandom;
      end
      @(negedge clk);
      vin[k] = 1'b1;
      pin[k] = pix[i];
    end
    @(negedge clk);
    vin[k] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vin[k] = 1'b0;
      pin[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (vout[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_valid dut=%0d got=%b want=0", k, vout[k]);
      end
      n_checks++;
      if (pout[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_pxl dut=%0d got=%h want=00000000", k, pout[k]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [31:0] exp_v [4];
    logic        want;
    exp_v = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    mon_q.delete();
    // Strobe must follow exactly the edge that accepts pixels 6, 8, 14, 16
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vin[1] = 1'b1;
      pin[1] = itof(i + 1);
      @(posedge clk);
      #1;
      want = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      n_checks++;
      if (vout[1] !== want) begin
        n_fail++;
        $display("FAIL basic_latency pixel=%0d got=%b want=%b", i + 1, vout[1], want);
      end
    end
    @(negedge clk);
    vin[1] = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (mon_q.size() != 4) begin
      n_fail++;
      $display("FAIL basic_count got=%0d want=4", mon_q.size());
    end
    for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[i].val !== exp_v[i] || mon_q[i].dut !== 2'd1) begin
        n_fail++;
        $display("FAIL basic_value idx=%0d got=%h(dut %0d) want=%h", i, mon_q[i].val, mon_q[i].dut, exp_v[i]);
      end
    end
    // Output holds its last value while idle
    n_checks++;
    if (pout[1] !== 32'h41800000 || vout[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold got=%h/%b want=41800000/0", pout[1], vout[1]);
    end
  endtask

  task automatic test_negatives;
    pq_t         pix;
    logic [31:0] exp_v [2];
    pix = '{32'hBF800000, 32'hC0000000, 32'hBF000000, 32'hC0400000,
            32'h80000000, 32'h80000000, 32'h80000000, 32'h00000000};
    exp_v = '{32'hBF000000, 32'h00000000};
    mon_q.delete();
    drive(0, pix, 0);
    n_checks++;
    if (mon_q.size() != 2) begin
      n_fail++;
      $display("FAIL neg_count got=%0d want=2", mon_q.size());
    end
    for (int i = 0; i < 2 && i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[i].val !== exp_v[i] || mon_q[i].dut !== 2'd0) begin
        n_fail++;
        $display("FAIL neg_value idx=%0d got=%h want=%h", i, mon_q[i].val, exp_v[i]);
      end
    end
  endtask

  task automatic test_odd_edge;
    logic [31:0] exp_v [4];
    exp_v = '{32'h40E00000, 32'h41100000, 32'h41880000, 32'h41980000};
    mon_q.delete();
    drive(2, ramp(25), 0);
    n_checks++;
    if (mon_q.size() != 4) begin
      n_fail++;
      $display("FAIL odd_count got=%0d want=4", mon_q.size());
    end
    for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[i].val !== exp_v[i] || mon_q[i].dut !== 2'd2) begin
        n_fail++;
        $display("FAIL odd_value idx=%0d got=%h want=%h", i, mon_q[i].val, exp_v[i]);
      end
    end
  endtask

  task automatic test_bubbles;
    logic [31:0] exp_v [4];
    exp_v = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    mon_q.delete();
    drive(1, ramp(16), 40);
    n_checks++;
    if (mon_q.size() != 4) begin
      n_fail++;
      $display("FAIL bubble_count got=%0d want=4", mon_q.size());
    end
    for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[i].val !== exp_v[i] || mon_q[i].dut !== 2'd1) begin
        n_fail++;
        $display("FAIL bubble_value idx=%0d got=%h want=%h", i, mon_q[i].val, exp_v[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    pq_t         head;
    logic [31:0] exp_v [4];
    exp_v = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    // Nine pixels of a frame of large values, then abort
    for (int i = 0; i < 9; i++) head.push_back(itof(100 + i));
    drive(1, head, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (vout[1] !== 1'b0 || pout[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_async got=%h/%b want=00000000/0", pout[1], vout[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    mon_q.delete();
    drive(1, ramp(16), 0);
    n_checks++;
    if (mon_q.size() != 4) begin
      n_fail++;
      $display("FAIL midreset_count got=%0d want=4", mon_q.size());
    end
    for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[i].val !== exp_v[i] || mon_q[i].dut !== 2'd1) begin
        n_fail++;
        $display("FAIL midreset_value idx=%0d got=%h want=%h", i, mon_q[i].val, exp_v[i]);
      end
    end
  endtask

  // Random frames on the D=11 instance, first gapless then with bubbles
  task automatic test_back_to_back(input int nframes, input int idle_pct);
    pq_t pix;
    pq_t exp_q;
    for (int i = 0; i < nframes * 121; i++) pix.push_back($urandom);
    exp_q = pool_ref(11, pix);
    mon_q.delete();
    drive(3, pix, idle_pct);
    n_checks++;
    if (mon_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_count idle=%0d got=%0d want=%0d", idle_pct, mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[i].val !== exp_q[i] || mon_q[i].dut !== 2'd3) begin
        n_fail++;
        $display("FAIL b2b_value idle=%0d idx=%0d got=%h want=%h", idle_pct, i, mon_q[i].val, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_negatives;
    test_odd_edge;
    test_bubbles;
    test_reset_mid;
    test_back_to_back(3, 0);
    test_back_to_back(2, 35);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
